// File: rtl/ex_hilo_pkg.sv
// Shared widths, ALU op/sel codes, constants and helpers for the execute stage.
package ex_hilo_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int ALUOP_W  = 8;
    localparam int ALUSEL_W = 3;

    localparam logic              WRITEENABLE = 1'b1;
    localparam logic              RSTENABLE   = 1'b1;
    localparam logic [DATA_W-1:0] ZEROWORD    = '0;

    // Result classes
    localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [ALUSEL_W-1:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [ALUSEL_W-1:0] EXE_RES_ARITH = 3'b100;

    // Operation codes
    localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [ALUOP_W-1:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [ALUOP_W-1:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [ALUOP_W-1:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [ALUOP_W-1:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [ALUOP_W-1:0] EXE_SLLV_OP  = 8'b0000_0100;
    localparam logic [ALUOP_W-1:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [ALUOP_W-1:0] EXE_SRLV_OP  = 8'b0000_0110;
    localparam logic [ALUOP_W-1:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [ALUOP_W-1:0] EXE_SRAV_OP  = 8'b0000_0111;
    localparam logic [ALUOP_W-1:0] EXE_MOVZ_OP  = 8'b0000_1010;
    localparam logic [ALUOP_W-1:0] EXE_MOVN_OP  = 8'b0000_1011;
    localparam logic [ALUOP_W-1:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [ALUOP_W-1:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [ALUOP_W-1:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [ALUOP_W-1:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [ALUOP_W-1:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [ALUOP_W-1:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [ALUOP_W-1:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [ALUOP_W-1:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [ALUOP_W-1:0] EXE_SUB_OP   = 8'b0010_0010;
    localparam logic [ALUOP_W-1:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [ALUOP_W-1:0] EXE_CLZ_OP   = 8'b1011_0000;
    localparam logic [ALUOP_W-1:0] EXE_CLO_OP   = 8'b1011_0001;
    localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [ALUOP_W-1:0] EXE_MUL_OP   = 8'b1010_1001;
    localparam logic [ALUOP_W-1:0] EXE_MADD_OP  = 8'b1010_0110;
    localparam logic [ALUOP_W-1:0] EXE_MADDU_OP = 8'b1010_1000;
    localparam logic [ALUOP_W-1:0] EXE_MSUB_OP  = 8'b1010_1010;
    localparam logic [ALUOP_W-1:0] EXE_MSUBU_OP = 8'b1010_1011;

    // Multiply-accumulate state machine
    typedef enum logic [0:0] {
        EX_MAC_IDLE = 1'b0,
        EX_MAC_ACC  = 1'b1
    } mac_state_e;

    // Leading-zero count, 0..32 (all-zero input yields 32)
    function automatic logic [5:0] count_leading_zeros(input logic [DATA_W-1:0] v);
        logic [5:0] cnt;
        logic       found;
        cnt   = 6'd32;
        found = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                cnt   = 6'(DATA_W - 1 - i);
                found = 1'b1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ex_hilo_mul64.sv
// Combinational 32x32 -> 64 multiplier, signed or unsigned per i_signed.
// Operands are extended to 64 bits first; the low 64 bits of that product
// are the exact signed/unsigned result in both modes.
module ex_mul64
    import ex_hilo_pkg::*;
(
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    input  logic                i_signed,
    output logic [2*DATA_W-1:0] o_prod
);

    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_b_ext;

    assign w_a_ext[DATA_W-1:0] = i_a;
    assign w_b_ext[DATA_W-1:0] = i_b;

    // Upper half is the sign bit in signed mode, zero otherwise
    for (genvar gi = DATA_W; gi < 2 * DATA_W; gi++) begin : g_ext
        assign w_a_ext[gi] = i_signed & i_a[DATA_W-1];
        assign w_b_ext[gi] = i_signed & i_b[DATA_W-1];
    end

    assign o_prod = w_a_ext * w_b_ext;

endmodule

// File: rtl/ex_hilo.sv
// Execute stage with HI/LO pair and 2-cycle multiply-accumulate.
// Optional build macro EX_OVF_CHECK_EN: signed overflow on ADD/SUB raises
// ovf_o and suppresses the register write; otherwise ovf_o is tied low.
module ex_hilo
    import ex_hilo_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic [ALUOP_W-1:0]  aluop_i,
    input  logic [ALUSEL_W-1:0] alusel_i,
    input  logic [DATA_W-1:0]   reg1_i,
    input  logic [DATA_W-1:0]   reg2_i,
    input  logic [ADDR_W-1:0]   wd_i,
    input  logic                wreg_i,
    output logic [ADDR_W-1:0]   wd_o,
    output logic                wreg_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o,
    output logic                ovf_o,
    output logic                stallreq
);

    mac_state_e            r_state;
    mac_state_e            w_state_next;
    logic [DATA_W-1:0]     r_hi;
    logic [DATA_W-1:0]     r_lo;
    logic [2*DATA_W-1:0]   r_temp;
    logic                  r_mac_sub;

    logic                  w_is_mac;
    logic                  w_mac_sub;
    logic                  w_mul_signed;
    logic [2*DATA_W-1:0]   w_prod;
    logic [2*DATA_W-1:0]   w_hilo_acc;
    logic [DATA_W-1:0]     w_sum;
    logic [DATA_W-1:0]     w_diff;
    logic [4:0]            w_shamt;
    logic [DATA_W-1:0]     w_result;
    logic                  w_ovf;
    logic                  w_stallreq;

    assign w_is_mac     = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MADDU_OP) ||
                          (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
    assign w_mac_sub    = (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
    assign w_mul_signed = (aluop_i == EXE_MUL_OP)  || (aluop_i == EXE_MULT_OP) ||
                          (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MSUB_OP);

    ex_mul64 u_mul (
        .i_a      (reg1_i),
        .i_b      (reg2_i),
        .i_signed (w_mul_signed),
        .o_prod   (w_prod)
    );

    assign w_sum      = reg1_i + reg2_i;
    assign w_diff     = reg1_i - reg2_i;
    assign w_shamt    = reg1_i[4:0];
    // Direction is latched with the product so a stray op in ACC cannot flip it
    assign w_hilo_acc = r_mac_sub ? ({r_hi, r_lo} - r_temp) : ({r_hi, r_lo} + r_temp);

`ifdef EX_OVF_CHECK_EN
    assign w_ovf = ((aluop_i == EXE_ADD_OP) && (reg1_i[DATA_W-1] == reg2_i[DATA_W-1]) &&
                    (w_sum[DATA_W-1] != reg1_i[DATA_W-1])) ||
                   ((aluop_i == EXE_SUB_OP) && (reg1_i[DATA_W-1] != reg2_i[DATA_W-1]) &&
                    (w_diff[DATA_W-1] != reg1_i[DATA_W-1]));
`else
    assign w_ovf = 1'b0;
`endif

    // MAC next state; stallreq only in the cycle the product is captured
    always_comb begin
        w_state_next = r_state;
        w_stallreq   = 1'b0;
        case (r_state)
            EX_MAC_IDLE: begin
                if (w_is_mac && !stall_i) begin
                    w_state_next = EX_MAC_ACC;
                    w_stallreq   = 1'b1;
                end
            end
            EX_MAC_ACC: begin
                if (!stall_i) begin
                    w_state_next = EX_MAC_IDLE;
                end
            end
            default: w_state_next = EX_MAC_IDLE;
        endcase
    end

    // MAC state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EX_MAC_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // HI/LO and product latch; everything frozen while stall_i is high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi      <= ZEROWORD;
            r_lo      <= ZEROWORD;
            r_temp    <= '0;
            r_mac_sub <= 1'b0;
        end else if (!stall_i) begin
            if (r_state == EX_MAC_ACC) begin
                {r_hi, r_lo} <= w_hilo_acc;
            end else if (w_is_mac) begin
                r_temp    <= w_prod;
                r_mac_sub <= w_mac_sub;
            end else begin
                case (aluop_i)
                    EXE_MTHI_OP:  r_hi <= reg1_i;
                    EXE_MTLO_OP:  r_lo <= reg1_i;
                    EXE_MULT_OP,
                    EXE_MULTU_OP: {r_hi, r_lo} <= w_prod;
                    default: ;
                endcase
            end
        end
    end

    // Result select by class, then by operation within the class
    always_comb begin
        w_result = ZEROWORD;
        case (alusel_i)
            EXE_RES_LOGIC: begin
                case (aluop_i)
                    EXE_OR_OP:  w_result = reg1_i | reg2_i;
                    EXE_AND_OP: w_result = reg1_i & reg2_i;
                    EXE_XOR_OP: w_result = reg1_i ^ reg2_i;
                    EXE_NOR_OP: w_result = ~(reg1_i | reg2_i);
                    default:    w_result = ZEROWORD;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (aluop_i)
                    EXE_SLL_OP, EXE_SLLV_OP: w_result = reg2_i << w_shamt;
                    EXE_SRL_OP, EXE_SRLV_OP: w_result = reg2_i >> w_shamt;
                    EXE_SRA_OP, EXE_SRAV_OP: w_result = $signed(reg2_i) >>> w_shamt;
                    default:                 w_result = ZEROWORD;
                endcase
            end
            EXE_RES_MOVE: begin
                case (aluop_i)
                    EXE_MFHI_OP:             w_result = r_hi;
                    EXE_MFLO_OP:             w_result = r_lo;
                    EXE_MOVN_OP, EXE_MOVZ_OP: w_result = reg1_i;
                    default:                 w_result = ZEROWORD;
                endcase
            end
            EXE_RES_ARITH: begin
                case (aluop_i)
                    EXE_ADD_OP, EXE_ADDU_OP: w_result = w_sum;
                    EXE_SUB_OP, EXE_SUBU_OP: w_result = w_diff;
                    EXE_SLT_OP:  w_result = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
                    EXE_SLTU_OP: w_result = {31'b0, reg1_i < reg2_i};
                    EXE_CLZ_OP:  w_result = {26'b0, count_leading_zeros(reg1_i)};
                    EXE_CLO_OP:  w_result = {26'b0, count_leading_zeros(~reg1_i)};
                    EXE_MUL_OP:  w_result = w_prod[DATA_W-1:0];
                    default:     w_result = ZEROWORD;
                endcase
            end
            default: w_result = ZEROWORD;
        endcase
    end

    assign wd_o     = rst ? '0       : wd_i;
    assign wreg_o   = rst ? 1'b0     : (wreg_i & ~w_ovf);
    assign wdata_o  = rst ? ZEROWORD : w_result;
    assign ovf_o    = rst ? 1'b0     : w_ovf;
    assign stallreq = rst ? 1'b0     : w_stallreq;
    assign hi_o     = r_hi;
    assign lo_o     = r_lo;

endmodule
